// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Holds the decoded instruction for one cycle, muxes forwarded results from the
// EX/MEM and MEM/WB stages onto the ALU operands, and requests an IF/ID freeze
// when the instruction in EX is a load whose destination the ID instruction reads.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic [3:0]  id_alu_sel,
    input  logic        id_asel,
    input  logic        id_bsel,
    input  logic        id_reg_wen,
    input  logic        id_mem_read,
    input  logic        stall,
    input  logic        flush,
    input  logic [4:0]  exmem_rd,
    input  logic        exmem_reg_wen,
    input  logic [31:0] exmem_result,
    input  logic [4:0]  memwb_rd,
    input  logic        memwb_reg_wen,
    input  logic [31:0] memwb_result,
    output logic [31:0] alu_inp1,
    output logic [31:0] alu_inp2,
    output logic [3:0]  alu_sel,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rd_addr,
    output logic        ex_reg_wen,
    output logic        ex_mem_read,
    output logic [31:0] ex_store_data,
    output logic        load_use_stall
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_rs1_data;
    logic [31:0] r_rs2_data;
    logic [31:0] r_imm;
    logic [4:0]  r_rs1_addr;
    logic [4:0]  r_rs2_addr;
    logic [4:0]  r_rd_addr;
    logic [3:0]  r_alu_sel;
    logic        r_asel;
    logic        r_bsel;
    logic        r_reg_wen;
    logic        r_mem_read;

    logic        w_load_use;
    logic [31:0] w_fwd_rs1;
    logic [31:0] w_fwd_rs2;

    // Youngest producer wins; x0 is never a forwarding target.
    function automatic logic [31:0] fwd_pick(input logic [4:0]  addr,
                                             input logic [31:0] reg_data);
        if (exmem_reg_wen && exmem_rd != 5'd0 && exmem_rd == addr)
            return exmem_result;
        else if (memwb_reg_wen && memwb_rd != 5'd0 && memwb_rd == addr)
            return memwb_result;
        else
            return reg_data;
    endfunction

    // Load in EX feeding a source of the ID instruction: data not ready yet.
    assign w_load_use = r_valid & r_mem_read & (r_rd_addr != 5'd0) & id_valid &
                        ((id_rs1_addr == r_rd_addr) | (id_rs2_addr == r_rd_addr));

    // Forwarding is purely combinational so a held instruction sees late results.
    always_comb begin
        w_fwd_rs1 = fwd_pick(r_rs1_addr, r_rs1_data);
        w_fwd_rs2 = fwd_pick(r_rs2_addr, r_rs2_data);
    end

    // Pipeline register: flush > stall > load-use bubble > capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd_addr  <= '0;
            r_alu_sel  <= '0;
            r_asel     <= 1'b0;
            r_bsel     <= 1'b0;
            r_reg_wen  <= 1'b0;
            r_mem_read <= 1'b0;
        end else if (flush || (!stall && w_load_use)) begin
            // Squash and bubble look identical: kill side effects, keep operands.
            r_valid    <= 1'b0;
            r_reg_wen  <= 1'b0;
            r_mem_read <= 1'b0;
            r_alu_sel  <= 4'b0000;
        end else if (!stall) begin
            r_valid    <= id_valid;
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1_addr <= id_rs1_addr;
            r_rs2_addr <= id_rs2_addr;
            r_rd_addr  <= id_rd_addr;
            r_alu_sel  <= id_alu_sel;
            r_asel     <= id_asel;
            r_bsel     <= id_bsel;
            // An invalid slot must never write the register file or memory.
            r_reg_wen  <= id_reg_wen & id_valid;
            r_mem_read <= id_mem_read & id_valid;
        end
    end

    assign alu_inp1       = r_asel ? r_pc  : w_fwd_rs1;
    assign alu_inp2       = r_bsel ? r_imm : w_fwd_rs2;
    assign ex_store_data  = w_fwd_rs2;
    assign alu_sel        = r_alu_sel;
    assign ex_valid       = r_valid;
    assign ex_pc          = r_pc;
    assign ex_rd_addr     = r_rd_addr;
    assign ex_reg_wen     = r_reg_wen;
    assign ex_mem_read    = r_mem_read;
    assign load_use_stall = w_load_use;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: id_valid in 1, id_pc in 32, id_rs1_data in 32, id_rs2_data in 32, id_imm in 32  decode-stage instruction, PC, register-file reads, immediate.
REQ-004 SHALL have: id_rs1_addr in 5, id_rs2_addr in 5, id_rd_addr in 5  decode-stage register indices.
REQ-005 SHALL have: id_alu_sel in 4  ALU op code (0000 add ... 1010 sra); id_asel in 1 (0 rs1, 1 pc); id_bsel in 1 (0 rs2, 1 imm); id_reg_wen in 1; id_mem_read in 1  load flag.
REQ-006 SHALL have: stall in 1  downstream hold request; flush in 1  squash request, e.g. taken branch.
REQ-007 SHALL have: exmem_rd in 5, exmem_reg_wen in 1, exmem_result in 32; memwb_rd in 5, memwb_reg_wen in 1, memwb_result in 32  forwarding sources.
REQ-008 SHALL have: alu_inp1 out 32, alu_inp2 out 32, alu_sel out 4  ALU operand and op outputs.
REQ-009 SHALL have: ex_valid out 1, ex_pc out 32, ex_rd_addr out 5, ex_reg_wen out 1, ex_mem_read out 1, ex_store_data out 32  forwarded rs2 value.
REQ-010 SHALL have: load_use_stall out 1  combinational request to freeze IF/ID.

Function
REQ-011 SHALL hold in internal registers: valid, pc, rs1_data, rs2_data, imm, rs1_addr, rs2_addr, rd_addr, alu_sel, asel, bsel, reg_wen, mem_read.
REQ-012 SHALL compute load_use_stall = ex_valid & ex_mem_read & (ex_rd_addr != 0) & id_valid & (id_rs1_addr == ex_rd_addr | id_rs2_addr == ex_rd_addr), combinationally.
REQ-013 SHALL apply the following update priority on each rising clk edge: flush > stall > load_use_stall > normal capture.
REQ-014 On flush, SHALL clear valid, reg_wen and mem_read, set alu_sel to 0000, and leave the other registers unchanged.
REQ-015 On stall without flush, SHALL hold all registers unchanged.
REQ-016 On load_use_stall without flush or stall, SHALL insert a bubble: valid, reg_wen and mem_read cleared, alu_sel set to 0000.
REQ-017 On normal capture, SHALL load all registers from the id_* inputs in the same edge, so latency is exactly 1 cycle from ID to EX.
REQ-018 SHALL capture an instruction with id_valid=0 as a bubble: reg_wen and mem_read forced to 0.
REQ-019 SHALL compute fwd_rs1 combinationally:
  - exmem_result when exmem_reg_wen & exmem_rd != 0 & exmem_rd == rs1_addr;
  - else memwb_result when memwb_reg_wen & memwb_rd != 0 & memwb_rd == rs1_addr;
  - else the registered rs1_data.
REQ-020 SHALL compute fwd_rs2 with the same rule as REQ-019, using rs2_addr.
REQ-021 SHALL never forward to register x0; an index of 0 always selects the registered data.
REQ-022 SHALL drive alu_inp1 = asel ? pc : fwd_rs1 and alu_inp2 = bsel ? imm : fwd_rs2, with 32-bit values passed unmodified and no sign or width change.
REQ-023 SHALL drive ex_store_data = fwd_rs2, regardless of bsel.
REQ-024 SHALL drive alu_sel, ex_pc, ex_rd_addr, ex_reg_wen, ex_mem_read and ex_valid directly from the registers.
REQ-025 SHALL re-evaluate forwarding every cycle while stalled, so a held instruction picks up results that retire during the stall.

Reset
REQ-026 While rst_n=0, SHALL asynchronously force every register to 0: ex_valid=0, alu_sel=0000, all data outputs 0, load_use_stall=0.
REQ-027 Reset asserted mid-operation SHALL discard the held instruction immediately, without waiting for a clk edge.
REQ-028 After rst_n deasserts, SHALL capture on the first rising edge.

Verification
REQ-029 SHALL pass: reset then capture id_pc=0x100, id_rs1_data=5, id_imm=7, bsel=1, alu_sel=0000 -> next cycle alu_inp1=5, alu_inp2=7, ex_valid=1.
REQ-030 SHALL pass: EX holds rs1_addr=3, exmem_rd=3 wen=1 result=0xAA, memwb_rd=3 wen=1 result=0xBB -> alu_inp1=0xAA; with exmem_reg_wen=0 -> 0xBB; with rs1_addr=0 and exmem_rd=0 -> registered data.
REQ-031 SHALL pass: EX load with rd=4 and ID rs2_addr=4 -> load_use_stall=1; next edge ex_valid=0, ex_reg_wen=0.
REQ-032 SHALL pass: flush and stall asserted together -> next edge ex_valid=0, alu_sel=0000; stall alone for 3 cycles -> outputs held, while a memwb change on a matching rd updates alu_inp2 during the stall.
REQ-033 SHALL pass: rst_n pulsed low between edges while ex_valid=1 -> ex_valid=0 immediately and all outputs 0.
